// File: rtl/mem_access.sv
// mem_access: MEM stage of the 16-bit pipeline.
// Drives a req/ack data bus with timeout and stalls upstream while busy.
`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b00010
`endif

module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] mem_ir,
  input  logic [15:0] reg_C,
  input  logic        dw,
  input  logic [15:0] smdr1,
  input  logic [15:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [15:0] dbus_addr,
  output logic [15:0] dbus_wdata,
  output logic [15:0] wb_ir,
  output logic [15:0] reg_C1,
  output logic        mem_stall,
  output logic        bus_err
);

  typedef enum logic {
    IDLE,
    ACCESS
  } fsm_t;

  fsm_t fsm, fsm_nx;

  logic [7:0]  cnt, cnt_d;
  logic        req_d, we_d, err_d;
  logic [15:0] addr_d, wdata_d;
  logic [15:0] wb_ir_d, reg_C1_d;

  logic is_load, memop, go;
  logic ack_hit, timeout_hit, done;
  logic [15:0] ld_data;

  assign is_load = (mem_ir[15:11] == `LOAD);
  assign memop   = is_load | dw;
  assign go      = (fsm == IDLE) & (state == `EXEC);
  assign ack_hit = (fsm == ACCESS) & dbus_ack;
  assign timeout_hit = (fsm == ACCESS) & !dbus_ack
                     & (cnt == 8'(TIMEOUT - 1));
  assign done    = ack_hit | timeout_hit;
  assign ld_data = dbus_ack ? dbus_rdata : 16'h0000;

  // Hold upstream while a launch or an unfinished access is pending.
  assign mem_stall = reset
                   & ((go & memop) | ((fsm == ACCESS) & !done));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fsm <= IDLE;
    else        fsm <= fsm_nx;
  end

  // Next-state logic.
  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      IDLE:   if (go & memop) fsm_nx = ACCESS;
      ACCESS: if (done)       fsm_nx = IDLE;
      default:                fsm_nx = IDLE;
    endcase
  end

  // Next values of the bus, WB and error registers.
  always_comb begin
    cnt_d    = cnt;
    req_d    = dbus_req;
    we_d     = dbus_we;
    addr_d   = dbus_addr;
    wdata_d  = dbus_wdata;
    wb_ir_d  = wb_ir;
    reg_C1_d = reg_C1;
    err_d    = bus_err;
    unique case (fsm)
      IDLE: begin
        if (go & memop) begin
          req_d   = 1'b1;
          we_d    = dw;
          addr_d  = reg_C;
          if (dw) wdata_d = smdr1;
          cnt_d   = 8'd0;
          wb_ir_d = 16'h0000;
        end else if (go) begin
          wb_ir_d  = mem_ir;
          reg_C1_d = reg_C;
        end
      end
      ACCESS: begin
        if (done) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          wb_ir_d  = mem_ir;
          reg_C1_d = is_load ? ld_data : reg_C;
          if (timeout_hit) err_d = 1'b1;
        end else begin
          cnt_d   = cnt + 8'd1;
          wb_ir_d = 16'h0000;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= 8'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 16'h0000;
      dbus_wdata <= 16'h0000;
      wb_ir      <= 16'h0000;
      reg_C1     <= 16'h0000;
      bus_err    <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      dbus_req   <= req_d;
      dbus_we    <= we_d;
      dbus_addr  <= addr_d;
      dbus_wdata <= wdata_d;
      wb_ir      <= wb_ir_d;
      reg_C1     <= reg_C1_d;
      bus_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of the MEM stage.
// Bus handshake, timeout, async reset and non-exec hold.
`timescale 1ns/1ps

module tb_mem_access;

  localparam logic [15:0] ADD_IR = 16'h4001;
  localparam logic [15:0] LD_IR  = 16'h1123;
  localparam logic [15:0] ST_IR  = 16'h1845;

  logic        clock;
  logic        reset;
  logic        state;
  logic [15:0] mem_ir;
  logic [15:0] reg_C;
  logic        dw;
  logic [15:0] smdr1;
  logic [15:0] dbus_rdata;
  logic        dbus_ack;
  logic        dbus_req;
  logic        dbus_we;
  logic [15:0] dbus_addr;
  logic [15:0] dbus_wdata;
  logic [15:0] wb_ir;
  logic [15:0] reg_C1;
  logic        mem_stall;
  logic        bus_err;

  int total;
  int bad;
  int reqs;
  int stalls;

  mem_access #(.TIMEOUT(16)) dut (
    .clock(clock),
    .reset(reset),
    .state(state),
    .mem_ir(mem_ir),
    .reg_C(reg_C),
    .dw(dw),
    .smdr1(smdr1),
    .dbus_rdata(dbus_rdata),
    .dbus_ack(dbus_ack),
    .dbus_req(dbus_req),
    .dbus_we(dbus_we),
    .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata),
    .wb_ir(wb_ir),
    .reg_C1(reg_C1),
    .mem_stall(mem_stall),
    .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    state = 1'b0;
    mem_ir = 16'h0000;
    reg_C = 16'h0000;
    dw = 1'b0;
    smdr1 = 16'h0000;
    dbus_rdata = 16'h0000;
    dbus_ack = 1'b0;
    #12;
    chk("rst_req", 16'(dbus_req), 16'h0);
    chk("rst_wb", wb_ir, 16'h0000);
    chk("rst_c1", reg_C1, 16'h0000);
    chk("rst_err", 16'(bus_err), 16'h0);
    chk("rst_stall", 16'(mem_stall), 16'h0);
    reset = 1'b1;
    step();

    // 1: ADD passthrough
    state = 1'b1;
    mem_ir = ADD_IR;
    reg_C = 16'h1234;
    #1;
    chk("add_stall", 16'(mem_stall), 16'h0);
    step();
    chk("add_wb", wb_ir, ADD_IR);
    chk("add_c1", reg_C1, 16'h1234);
    chk("add_req", 16'(dbus_req), 16'h0);

    // 2: LOAD, ack on 3rd ACCESS cycle
    mem_ir = LD_IR;
    reg_C = 16'h0040;
    #1;
    chk("ld_stall0", 16'(mem_stall), 16'h1);
    step();
    chk("ld_req", 16'(dbus_req), 16'h1);
    chk("ld_addr", dbus_addr, 16'h0040);
    chk("ld_we", 16'(dbus_we), 16'h0);
    chk("ld_bub1", wb_ir, 16'h0000);
    chk("ld_stall1", 16'(mem_stall), 16'h1);
    step();
    chk("ld_bub2", wb_ir, 16'h0000);
    chk("ld_stall2", 16'(mem_stall), 16'h1);
    chk("ld_req2", 16'(dbus_req), 16'h1);
    step();
    dbus_ack = 1'b1;
    dbus_rdata = 16'hBEEF;
    #1;
    chk("ld_stall3", 16'(mem_stall), 16'h0);
    step();
    dbus_ack = 1'b0;
    dbus_rdata = 16'h0000;
    chk("ld_wb", wb_ir, LD_IR);
    chk("ld_c1", reg_C1, 16'hBEEF);
    chk("ld_reqoff", 16'(dbus_req), 16'h0);

    // 3: STORE, ack in 1st ACCESS cycle
    mem_ir = ST_IR;
    dw = 1'b1;
    smdr1 = 16'h5A5A;
    reg_C = 16'h0010;
    step();
    chk("st_req", 16'(dbus_req), 16'h1);
    chk("st_we", 16'(dbus_we), 16'h1);
    chk("st_wd", dbus_wdata, 16'h5A5A);
    chk("st_addr", dbus_addr, 16'h0010);
    dbus_ack = 1'b1;
    #1;
    chk("st_stall", 16'(mem_stall), 16'h0);
    step();
    dbus_ack = 1'b0;
    chk("st_wb", wb_ir, ST_IR);
    chk("st_c1", reg_C1, 16'h0010);
    chk("st_weoff", 16'(dbus_we), 16'h0);
    chk("st_err", 16'(bus_err), 16'h0);

    // 4: LOAD with no ack -> timeout
    mem_ir = LD_IR;
    dw = 1'b0;
    reg_C = 16'h0080;
    step();
    reqs = 0;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dbus_req) break;
      reqs++;
      if (mem_stall) stalls++;
      step();
    end
    mem_ir = ADD_IR;
    reg_C = 16'h0BAD;
    chk("to_reqcyc", 16'(reqs), 16'd16);
    chk("to_stallcyc", 16'(stalls), 16'd15);
    chk("to_err", 16'(bus_err), 16'h1);
    chk("to_c1", reg_C1, 16'h0000);
    chk("to_wb", wb_ir, LD_IR);
    #1;
    chk("to_stall", 16'(mem_stall), 16'h0);
    step();
    chk("to_add_wb", wb_ir, ADD_IR);
    chk("to_add_c1", reg_C1, 16'h0BAD);
    chk("to_sticky", 16'(bus_err), 16'h1);

    // 5: reset in 2nd ACCESS cycle
    mem_ir = LD_IR;
    reg_C = 16'h0200;
    step();
    step();
    chk("r5_req_pre", 16'(dbus_req), 16'h1);
    reset = 1'b0;
    #1;
    chk("r5_req", 16'(dbus_req), 16'h0);
    chk("r5_stall", 16'(mem_stall), 16'h0);
    chk("r5_wb", wb_ir, 16'h0000);
    chk("r5_c1", reg_C1, 16'h0000);
    chk("r5_err", 16'(bus_err), 16'h0);
    state = 1'b0;
    #2;
    reset = 1'b1;
    step();
    chk("r5_noexec", 16'(dbus_req), 16'h0);
    state = 1'b1;
    step();
    chk("r5_relaunch", 16'(dbus_req), 16'h1);
    chk("r5_addr", dbus_addr, 16'h0200);
    dbus_ack = 1'b1;
    dbus_rdata = 16'h1111;
    step();
    dbus_ack = 1'b0;
    state = 1'b0;
    chk("r5_wb2", wb_ir, LD_IR);
    chk("r5_c1b", reg_C1, 16'h1111);

    // 6: not exec -> nothing moves, stray ack ignored
    mem_ir = ADD_IR;
    reg_C = 16'h7777;
    dbus_ack = 1'b1;
    dbus_rdata = 16'h2222;
    step();
    dbus_ack = 1'b0;
    chk("n6_wb", wb_ir, LD_IR);
    chk("n6_c1", reg_C1, 16'h1111);
    chk("n6_req", 16'(dbus_req), 16'h0);
    mem_ir = LD_IR;
    #1;
    chk("n6_stall", 16'(mem_stall), 16'h0);
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    step();
    chk("n6_ldreq", 16'(dbus_req), 16'h0);
    chk("n6_ldwb", wb_ir, LD_IR);
    chk("n6_ldc1", reg_C1, 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
